router_sync: RTL and testbench

Channel-select and timeout block for the 1x3 router. It latches the destination address from the packet header, steers the FSM's single write strobe to one of the three output FIFOs, and reports that FIFO's full flag back to the FSM. It also generates per-channel valid and soft-reset signals. It sits between the router FSM/input register stage and the three router FIFOs: it drives each FIFO's write enable and soft reset, and presents the FIFOs' empty state to the destination as valid.

---
 rtl/router_sync.sv | 130 +++++++++++++
 tb/tb_router_sync.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/router_sync.sv
// Channel select and per-channel timeout for the 1x3 router.
// Optional timeout/soft-reset logic is built only when ROUTER_SYNC_TIMEOUT_EN is defined.
module router_sync #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  logic [1:0] addr_q;
  logic [1:0] addr_d;

  // Address 3 is the idle value: nothing is steered until a header is seen.
  always_comb begin
    addr_d = addr_q;
    if (detect_add) begin
      addr_d = data_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= 2'b11;
    end else begin
      addr_q <= addr_d;
    end
  end

  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      2'd0: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'd1: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'd2: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

`ifdef ROUTER_SYNC_TIMEOUT_EN
  localparam logic [5:0] CntLast = 6'(TIMEOUT - 1);

  logic [2:0] vldVec;
  logic [2:0] readVec;
  logic [5:0] cnt_q [3];
  logic [5:0] cnt_d [3];
  logic [2:0] softReset_q;
  logic [2:0] softReset_d;

  assign vldVec  = {vld_out_2, vld_out_1, vld_out_0};
  assign readVec = {read_enb_2, read_enb_1, read_enb_0};

  // A read or an empty FIFO restarts the count; reaching the limit fires one pulse and restarts.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]       = 6'd0;
      softReset_d[i] = 1'b0;
      if (vldVec[i] && !readVec[i]) begin
        if (cnt_q[i] == CntLast) begin
          softReset_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= 6'd0;
      end
      softReset_q <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      softReset_q <= softReset_d;
    end
  end

  assign soft_reset_0 = softReset_q[0];
  assign soft_reset_1 = softReset_q[1];
  assign soft_reset_2 = softReset_q[2];
`else
  logic unusedSignals;
  assign unusedSignals = ^{read_enb_0, read_enb_1, read_enb_2, 6'(TIMEOUT)};

  assign soft_reset_0 = 1'b0;
  assign soft_reset_1 = 1'b0;
  assign soft_reset_2 = 1'b0;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Self-checking bench for router_sync: directed scenarios plus randomized traffic
// compared every cycle against a streak-counting behavioural model.
module tb_router_sync;

  localparam int TO = 30;
`ifdef ROUTER_SYNC_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       detectAdd = 1'b0;
  logic [1:0] dataIn = 2'b00;
  logic       writeEnbReg = 1'b0;
  logic [2:0] readEnb = 3'b000;
  logic [2:0] empty = 3'b111;
  logic [2:0] full = 3'b000;

  logic [2:0] writeEnb;
  logic       fifoFull;
  logic [2:0] vldOut;
  logic [2:0] softReset;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  // Model state: selected address and the length of each channel's unread-valid streak.
  logic [1:0] mAddr = 2'b11;
  int         mStreak [3] = '{0, 0, 0};
  logic [2:0] mSoft = 3'b000;

  router_sync #(.TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn),
    .detect_add(detectAdd), .data_in(dataIn), .write_enb_reg(writeEnbReg),
    .read_enb_0(readEnb[0]), .read_enb_1(readEnb[1]), .read_enb_2(readEnb[2]),
    .empty_0(empty[0]), .empty_1(empty[1]), .empty_2(empty[2]),
    .full_0(full[0]), .full_1(full[1]), .full_2(full[2]),
    .write_enb(writeEnb), .fifo_full(fifoFull),
    .vld_out_0(vldOut[0]), .vld_out_1(vldOut[1]), .vld_out_2(vldOut[2]),
    .soft_reset_0(softReset[0]), .soft_reset_1(softReset[1]), .soft_reset_2(softReset[2])
  );

  always #5 clock = ~clock;

  // A pulse is due whenever an unbroken streak reaches a whole multiple of the timeout.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mAddr = 2'b11;
      for (int c = 0; c < 3; c++) mStreak[c] = 0;
      mSoft = 3'b000;
    end else begin
      if (detectAdd) mAddr = dataIn;
      for (int c = 0; c < 3; c++) begin
        if (empty[c] || readEnb[c]) begin
          mStreak[c] = 0;
          mSoft[c] = 1'b0;
        end else begin
          mStreak[c] = mStreak[c] + 1;
          mSoft[c] = TimeoutEn && (mStreak[c] % TO == 0);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle: compare all outputs with what the model says they must be.
  always @(negedge clock) begin
    if (checkEn) begin
      logic [2:0] expWe;
      logic       expFull;
      expWe   = (mAddr != 2'b11 && writeEnbReg) ? (3'b001 << mAddr) : 3'b000;
      expFull = (mAddr == 2'b11) ? 1'b0 : full[mAddr];
      checkOutput("write_enb", {5'd0, writeEnb}, {5'd0, expWe});
      checkOutput("fifo_full", {7'd0, fifoFull}, {7'd0, expFull});
      checkOutput("vld_out", {5'd0, vldOut}, {5'd0, ~empty});
      checkOutput("soft_reset", {5'd0, softReset}, {5'd0, mSoft});
    end
  end

  // Waits for one rising edge, then drives the next input set a little after it.
  task automatic applyStimulus(input logic rn, input logic da, input logic [1:0] di,
                               input logic wr, input logic [2:0] rd, input logic [2:0] em,
                               input logic [2:0] fu);
    @(posedge clock);
    #2;
    resetn = rn; detectAdd = da; dataIn = di; writeEnbReg = wr;
    readEnb = rd; empty = em; full = fu;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    checkOutput("reset write_enb", {5'd0, writeEnb}, 8'h00);
    checkOutput("reset fifo_full", {7'd0, fifoFull}, 8'h00);
    checkOutput("reset vld_out", {5'd0, vldOut}, 8'h00);
    checkOutput("reset soft_reset", {5'd0, softReset}, 8'h00);
    checkEn = 1'b1;

    applyStimulus(1, 0, 2'b00, 1, 3'b000, 3'b111, 3'b000);
    applyStimulus(1, 0, 2'b00, 1, 3'b000, 3'b111, 3'b000);
    #1 checkOutput("no-addr write_enb", {5'd0, writeEnb}, 8'h00);

    // Steer to channel 2; the load and the write in the same cycle still decode the old address.
    applyStimulus(1, 1, 2'b10, 1, 3'b000, 3'b111, 3'b100);
    #1 checkOutput("old-addr write_enb", {5'd0, writeEnb}, 8'h00);
    applyStimulus(1, 0, 2'b00, 1, 3'b000, 3'b111, 3'b100);
    #1 checkOutput("steer write_enb", {5'd0, writeEnb}, 8'h04);
    checkOutput("steer fifo_full", {7'd0, fifoFull}, 8'h01);
    applyStimulus(1, 0, 2'b00, 1, 3'b000, 3'b111, 3'b001);
    #1 checkOutput("full_0 ignored", {7'd0, fifoFull}, 8'h00);

    applyStimulus(1, 1, 2'b11, 1, 3'b000, 3'b111, 3'b111);
    applyStimulus(1, 0, 2'b00, 1, 3'b000, 3'b111, 3'b111);
    #1 checkOutput("invalid write_enb", {5'd0, writeEnb}, 8'h00);
    checkOutput("invalid fifo_full", {7'd0, fifoFull}, 8'h00);

    // Channel 1 valid and unread: pulses after edges 30 and 60.
    applyStimulus(1, 0, 2'b00, 0, 3'b000, 3'b101, 3'b000);
    for (int k = 1; k <= 61; k++) begin
      applyStimulus(1, 0, 2'b00, 0, 3'b000, 3'b101, 3'b000);
      if (k == 29 || k == 30 || k == 31 || k == 60) begin
        #1 checkOutput($sformatf("timeout edge %0d", k), {5'd0, softReset},
                       {5'd0, 1'b0, TimeoutEn && (k == 30 || k == 60), 1'b0});
      end
    end

    // Rescue: a read on edge 30 cancels the pulse and restarts counting.
    applyStimulus(1, 0, 2'b00, 0, 3'b000, 3'b111, 3'b000);
    applyStimulus(1, 0, 2'b00, 0, 3'b000, 3'b101, 3'b000);
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1, 0, 2'b00, 0, (k == 29) ? 3'b010 : 3'b000, 3'b101, 3'b000);
      if (k == 30 || k == 59 || k == 60) begin
        #1 checkOutput($sformatf("rescue edge %0d", k), {5'd0, softReset},
                       {5'd0, 1'b0, TimeoutEn && (k == 60), 1'b0});
      end
    end

    // Randomized traffic with sparse reads and occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] rd;
      logic [2:0] em;
      for (int c = 0; c < 3; c++) begin
        rd[c] = ($urandom_range(0, 39) == 0);
        em[c] = ($urandom_range(0, 19) == 0);
      end
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, em,
                    3'($urandom_range(0, 7)));
    end
    applyStimulus(1, 0, 2'b00, 0, 3'b000, 3'b111, 3'b000);
    @(posedge clock);
    @(negedge clock);
    #1;
    checkEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
